// File: rtl/fp7_alu_issue_ctrl.sv
// Issue controller for the fp7 add pipeline: round-robin arbitration between the
// systolic column source (0) and the bias injector (1), RAW hazard blocking on
// accumulator entries still in flight, write-back tracking and a drain handshake.
module fp7_alu_issue_ctrl #(
  parameter int unsigned EXPONENT_WIDTH = 8,
  parameter int unsigned MANTISSA_WIDTH = 24,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned ALU_LATENCY    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s0_valid,
  output logic                      s0_ready,
  input  logic [ADDR_WIDTH-1:0]     s0_addr,
  input  logic [EXPONENT_WIDTH-1:0] s0_exponent,
  input  logic [MANTISSA_WIDTH-1:0] s0_mantissa,
  input  logic                      s1_valid,
  output logic                      s1_ready,
  input  logic [ADDR_WIDTH-1:0]     s1_addr,
  input  logic [EXPONENT_WIDTH-1:0] s1_exponent,
  input  logic [MANTISSA_WIDTH-1:0] s1_mantissa,
  output logic                      issue_valid,
  output logic                      issue_src,
  output logic [ADDR_WIDTH-1:0]     acc_rd_addr,
  output logic [EXPONENT_WIDTH-1:0] exponent_b,
  output logic [MANTISSA_WIDTH-1:0] mantissa_b,
  output logic                      wb_valid,
  output logic [ADDR_WIDTH-1:0]     wb_addr,
  input  logic                      drain_req,
  output logic                      drain_done,
  output logic                      busy
);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e                    state_q;
  logic                      drain_done_q;
  logic                      prio_q;

  // Issue register
  logic                      i_valid_q;
  logic [ADDR_WIDTH-1:0]     i_addr_q;
  logic                      i_src_q;
  logic [EXPONENT_WIDTH-1:0] i_exp_q;
  logic [MANTISSA_WIDTH-1:0] i_mant_q;

  // Tracking chain, one stage per pipeline cycle
  logic [ALU_LATENCY-1:0]    t_valid_q;
  logic [ADDR_WIDTH-1:0]     t_addr_q [ALU_LATENCY];

  logic hazard0, hazard1, run_ok, elig0, elig1, grant0, grant1, pipe_empty;

  // Hazard detect against the issue register and every tracking stage; the
  // exiting stage counts because its write lands at the end of this cycle.
  always_comb begin
    hazard0 = i_valid_q && (s0_addr == i_addr_q);
    hazard1 = i_valid_q && (s1_addr == i_addr_q);
    for (int unsigned k = 0; k < ALU_LATENCY; k++) begin
      if (t_valid_q[k] && (s0_addr == t_addr_q[k])) hazard0 = 1'b1;
      if (t_valid_q[k] && (s1_addr == t_addr_q[k])) hazard1 = 1'b1;
    end
  end

  // Round-robin grant; drain_req blocks grants already in the cycle it is first seen.
  always_comb begin
    run_ok     = (state_q == StRun) && !drain_req && !rst;
    elig0      = s0_valid && !hazard0 && run_ok;
    elig1      = s1_valid && !hazard1 && run_ok;
    grant0     = elig0 && (!elig1 || !prio_q);
    grant1     = elig1 && (!elig0 || prio_q);
    pipe_empty = !i_valid_q && !(|t_valid_q);
  end

  // Drain FSM with registered drain_done
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      drain_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          drain_done_q <= 1'b0;
          if (drain_req) state_q <= StDrain;
        end
        StDrain: begin
          if (!drain_req) begin
            state_q      <= StRun;
            drain_done_q <= 1'b0;
          end else if (pipe_empty) begin
            state_q      <= StDone;
            drain_done_q <= 1'b1;
          end
        end
        StDone: begin
          if (!drain_req) begin
            state_q      <= StRun;
            drain_done_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= StRun;
          drain_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Issue register and arbitration pointer; data fields hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q    <= 1'b0;
      i_valid_q <= 1'b0;
      i_addr_q  <= '0;
      i_src_q   <= 1'b0;
      i_exp_q   <= '0;
      i_mant_q  <= '0;
    end else begin
      i_valid_q <= grant0 || grant1;
      if (grant0) begin
        prio_q   <= 1'b1;
        i_addr_q <= s0_addr;
        i_src_q  <= 1'b0;
        i_exp_q  <= s0_exponent;
        i_mant_q <= s0_mantissa;
      end else if (grant1) begin
        prio_q   <= 1'b0;
        i_addr_q <= s1_addr;
        i_src_q  <= 1'b1;
        i_exp_q  <= s1_exponent;
        i_mant_q <= s1_mantissa;
      end
    end
  end

  // Tracking shift chain; reset discards in-flight ops so no write-back occurs for them.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_valid_q <= '0;
      for (int unsigned k = 0; k < ALU_LATENCY; k++) t_addr_q[k] <= '0;
    end else begin
      t_valid_q   <= {t_valid_q[ALU_LATENCY-2:0], i_valid_q};
      t_addr_q[0] <= i_addr_q;
      for (int unsigned k = 1; k < ALU_LATENCY; k++) t_addr_q[k] <= t_addr_q[k-1];
    end
  end

  assign s0_ready    = grant0;
  assign s1_ready    = grant1;
  assign issue_valid = i_valid_q;
  assign issue_src   = i_src_q;
  assign acc_rd_addr = i_addr_q;
  assign exponent_b  = i_exp_q;
  assign mantissa_b  = i_mant_q;
  assign wb_valid    = t_valid_q[ALU_LATENCY-1];
  assign wb_addr     = t_addr_q[ALU_LATENCY-1];
  assign drain_done  = drain_done_q;
  assign busy        = !pipe_empty;

endmodule
